banked_status_register: RTL
===========================

Name: banked_status_register

Overview:
Parametrised ARM program status register block holding CPSR plus one banked SPSR per exception mode (FIQ, IRQ, SVC, ABT, UND).
- Supports ALU flag updates, MSR field-masked writes, exception entry (CPSR saved to target SPSR) and exception return (SPSR restored to CPSR).
- Sits beside the register file in the datapath; control unit drives the strobes, and the condition-check logic and mode-banked register file consume CPSR/MODE.

Parameters:
WIDTH, 32, status word width; mode/flag bit positions fixed by shared package, WIDTH >= 32
NUM_BANKS, 5, number of SPSR banks (FIQ, IRQ, SVC, ABT, UND)
RESET_VALUE, 32'h000000D3, CPSR after CLR (SVC mode, I=1, F=1, T=0, flags 0)

Ports:
CLK  in  1  clock; all state updates on negedge
CLR  in  1  reset, asynchronous, active-low
FLAG_LE  in  1  active-low; load NZCV from FLAGS_IN
FLAGS_IN  in  4  {N,Z,C,V} from ALU
MSR_LE  in  1  active-low; MSR write
MSR_SPSR  in  1  1 = MSR targets current mode's SPSR, 0 = CPSR
MSR_MASK  in  4  field mask {f[31:24], s[23:16], x[15:8], c[7:0]}
MSR_D  in  WIDTH  MSR write data
EXC_LE  in  1  active-low; exception entry
EXC_MODE  in  5  target mode encoding for exception
RET_LE  in  1  active-low; exception return (CPSR <= SPSR_current)
CPSR  out  WIDTH  current status register
SPSR  out  WIDTH  SPSR of current mode, 0 in USR/SYS
MODE  out  5  CPSR[4:0]
PRIV  out  1  1 when MODE != USR
ERR  out  1  one-cycle pulse on an ignored or illegal request

Behaviour:
- Reset: CLR low asynchronously forces CPSR = RESET_VALUE, all SPSR banks = 0, ERR = 0. CLR mid-operation aborts any pending update.
- Updates: all on negedge CLK; outputs registered; one-edge latency. Strobes held high cause no state change.
- Priority (highest first): EXC_LE > RET_LE > MSR_LE > FLAG_LE.
  - A lower-priority CPSR write in the same edge is dropped.
  - Exception: MSR to SPSR and FLAG_LE combined in one edge both apply; FLAG_LE wins the CPSR flags over an MSR to CPSR f-field only if MSR_MASK[3] = 0.
- Mode codes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111. Any other code is illegal.
- Exception entry, for legal banked EXC_MODE:
  - SPSR[EXC_MODE] <= CPSR value before the edge.
  - CPSR[4:0] <= EXC_MODE; I <= 1; F <= 1 only if EXC_MODE = FIQ (else unchanged); T <= 0; flags unchanged.
  - EXC_MODE of USR, SYS or illegal: no change, ERR = 1.
- Exception return: in banked mode, CPSR <= SPSR[current]. In USR/SYS, or if the restored mode is illegal: no change, ERR = 1.
- MSR:
  - Each byte i of the target is written from MSR_D when MSR_MASK[i] = 1.
  - In USR mode to CPSR, only the f byte is writable; other set mask bits are ignored and raise ERR.
  - If the c byte would set an illegal mode: the c byte is dropped entirely, ERR = 1.
  - MSR_SPSR = 1 in USR/SYS: ignored, ERR = 1.
- Flag update: CPSR[31:28] <= FLAGS_IN; other bits kept.
- Bits above 31 (WIDTH > 32) are reserved: written only by MSR f-byte extension, cleared on reset.
- ERR deasserts on the next edge with no error.

Decomposition:
- Package arm_psr_pkg holds:
  - Mode encodings as constants.
  - Bit positions N=31, Z=30, C=29, V=28, I=7, F=6, T=5, M=4:0.
  - Function mode_to_bank (mode -> bank index, plus valid bit).
  - Function mode_is_legal.
- Sub-module spsr_bank: NUM_BANKS x WIDTH register array with async active-low CLR, a write index/enable, a read index, and a read-data-zero when the index is invalid.

Test Plan:
- CLR low mid-cycle -> CPSR = 0x000000D3 immediately, SPSR = 0, MODE = 10011, PRIV = 1, ERR = 0.
- FLAG_LE = 0, FLAGS_IN = 4'b1010 -> CPSR = 0xA00000D3 after one negedge; all other bits unchanged.
- From SVC CPSR = 0xA00000D3, EXC_LE = 0 with EXC_MODE = FIQ -> CPSR = 0xA00000D1, SPSR = 0xA00000D3. Then RET_LE = 0 -> CPSR = 0xA00000D3.
- CPSR = 0x00000010 (USR), MSR_LE = 0, MASK = 4'b1001, MSR_D = 0xF00000D3 -> CPSR = 0xF0000010, ERR pulses 1 cycle.
- In SVC, MSR to CPSR c byte = 0x14 (illegal) -> mode stays SVC, ERR = 1. RET_LE = 0 in SYS -> no change, ERR = 1.
- Same edge: EXC_LE = 0 (IRQ) plus FLAG_LE = 0 (1111) -> flags unchanged, CPSR = 0x000000D2 from 0x000000D3, SPSR_IRQ = 0x000000D3.

Source files
------------

// File: rtl/arm_psr_pkg.sv
// Shared PSR definitions: mode encodings, status bit positions,
// mode-to-bank mapping and mode legality helpers.
package arm_psr_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int BIT_N = 31;
    localparam int BIT_Z = 30;
    localparam int BIT_C = 29;
    localparam int BIT_V = 28;
    localparam int BIT_I = 7;
    localparam int BIT_F = 6;
    localparam int BIT_T = 5;

    localparam int BANK_W = 3;

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] idx;
    } bank_sel_t;

    // USR and SYS share the user register view and own no SPSR.
    function automatic bank_sel_t mode_to_bank(input logic [4:0] mode);
        bank_sel_t sel;
        sel = '0;
        case (mode)
            MODE_FIQ: sel = '{valid: 1'b1, idx: 3'd0};
            MODE_IRQ: sel = '{valid: 1'b1, idx: 3'd1};
            MODE_SVC: sel = '{valid: 1'b1, idx: 3'd2};
            MODE_ABT: sel = '{valid: 1'b1, idx: 3'd3};
            MODE_UND: sel = '{valid: 1'b1, idx: 3'd4};
            default:  sel = '0;
        endcase
        return sel;
    endfunction

    function automatic logic mode_is_legal(input logic [4:0] mode);
        return (mode == MODE_USR) || (mode == MODE_SYS) ||
               mode_to_bank(mode).valid;
    endfunction

endpackage

// File: rtl/spsr_bank.sv
// Banked SPSR storage: NUM_BANKS x WIDTH registers, negedge clocked.
// Ports: CLK, CLR (async active-low), we/wr_idx/wr_data write port,
// rd_valid/rd_idx read port, rd_data (zero for invalid index).
module spsr_bank
    import arm_psr_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_BANKS = 5
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              we,
    input  logic [BANK_W-1:0] wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_valid,
    input  logic [BANK_W-1:0] rd_idx,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [NUM_BANKS];

    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_idx) < NUM_BANKS)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_valid && (int'(rd_idx) < NUM_BANKS)) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/banked_status_register.sv
// ARM program status register block: CPSR plus banked SPSRs.
// Ports: CLK, CLR (async active-low), FLAG_LE/FLAGS_IN flag load,
// MSR_LE/MSR_SPSR/MSR_MASK/MSR_D field write, EXC_LE/EXC_MODE entry,
// RET_LE return; outputs CPSR, SPSR, MODE, PRIV, ERR (1-cycle pulse).
module banked_status_register
    import arm_psr_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NUM_BANKS   = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(32'h000000D3)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             FLAG_LE,
    input  logic [3:0]       FLAGS_IN,
    input  logic             MSR_LE,
    input  logic             MSR_SPSR,
    input  logic [3:0]       MSR_MASK,
    input  logic [WIDTH-1:0] MSR_D,
    input  logic             EXC_LE,
    input  logic [4:0]       EXC_MODE,
    input  logic             RET_LE,
    output logic [WIDTH-1:0] CPSR,
    output logic [WIDTH-1:0] SPSR,
    output logic [4:0]       MODE,
    output logic             PRIV,
    output logic             ERR
);

    logic [WIDTH-1:0]  cpsr_q;
    logic [WIDTH-1:0]  cpsr_n;
    logic              err_q;
    logic              err_n;
    logic              bank_we;
    logic [BANK_W-1:0] bank_idx;
    logic [WIDTH-1:0]  bank_wd;
    logic [WIDTH-1:0]  spsr_rd;
    logic [3:0]        eff_mask;
    logic [WIDTH-1:0]  bit_mask;
    bank_sel_t         cur_sel;
    bank_sel_t         exc_sel;

    assign cur_sel = mode_to_bank(cpsr_q[4:0]);
    assign exc_sel = mode_to_bank(EXC_MODE);

    // Byte enables to bit enables; the f-byte enable also covers any
    // reserved bits above 31.
    function automatic logic [WIDTH-1:0] expand(input logic [3:0] m);
        logic [WIDTH-1:0] e;
        e = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= 24) e[i] = m[3];
            else         e[i] = m[i>>3];
        end
        return e;
    endfunction

    spsr_bank #(
        .WIDTH     (WIDTH),
        .NUM_BANKS (NUM_BANKS)
    ) u_spsr_bank (
        .CLK      (CLK),
        .CLR      (CLR),
        .we       (bank_we),
        .wr_idx   (bank_idx),
        .wr_data  (bank_wd),
        .rd_valid (cur_sel.valid),
        .rd_idx   (cur_sel.idx),
        .rd_data  (spsr_rd)
    );

    always_comb begin
        cpsr_n   = cpsr_q;
        err_n    = 1'b0;
        bank_we  = 1'b0;
        bank_idx = cur_sel.idx;
        bank_wd  = spsr_rd;
        eff_mask = MSR_MASK;
        bit_mask = '0;
        if (!EXC_LE) begin
            if (exc_sel.valid) begin
                bank_we          = 1'b1;
                bank_idx         = exc_sel.idx;
                bank_wd          = cpsr_q;
                cpsr_n[4:0]      = EXC_MODE;
                cpsr_n[BIT_I]    = 1'b1;
                cpsr_n[BIT_T]    = 1'b0;
                if (EXC_MODE == MODE_FIQ) begin
                    cpsr_n[BIT_F] = 1'b1;
                end
            end else begin
                err_n = 1'b1;
            end
        end else if (!RET_LE) begin
            if (cur_sel.valid && mode_is_legal(spsr_rd[4:0])) begin
                cpsr_n = spsr_rd;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            if (!MSR_LE) begin
                if (MSR_SPSR && !cur_sel.valid) begin
                    err_n    = 1'b1;
                    eff_mask = '0;
                end else if (!MSR_SPSR && cpsr_q[4:0] == MODE_USR) begin
                    // User code may only touch the flag byte.
                    if (|MSR_MASK[2:0]) err_n = 1'b1;
                    eff_mask[2:0] = '0;
                end
                if (eff_mask[0] && !mode_is_legal(MSR_D[4:0])) begin
                    eff_mask[0] = 1'b0;
                    err_n       = 1'b1;
                end
                bit_mask = expand(eff_mask);
                if (MSR_SPSR) begin
                    bank_we = cur_sel.valid;
                    bank_wd = (spsr_rd & ~bit_mask) | (MSR_D & bit_mask);
                end else begin
                    cpsr_n = (cpsr_q & ~bit_mask) | (MSR_D & bit_mask);
                end
            end
            // ALU flags lose only to an MSR that names the CPSR f-field.
            if (!FLAG_LE && (MSR_LE || MSR_SPSR || !MSR_MASK[3])) begin
                cpsr_n[BIT_N:BIT_V] = FLAGS_IN;
            end
        end
    end

    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) begin
            cpsr_q <= RESET_VALUE;
            err_q  <= 1'b0;
        end else begin
            cpsr_q <= cpsr_n;
            err_q  <= err_n;
        end
    end

    assign CPSR = cpsr_q;
    assign SPSR = spsr_rd;
    assign MODE = cpsr_q[4:0];
    assign PRIV = (cpsr_q[4:0] != MODE_USR);
    assign ERR  = err_q;

endmodule
